mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared cache/memory definitions: line and address geometry, arbiter state and grant encodings.
// Used by both caches and the physical-memory arbiter.
package mem_arbiter_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Round-robin tie break: whoever did not win last time goes next.
    function automatic grant_t rr_pick(input grant_t last);
        return (last == GRANT_D) ? GRANT_I : GRANT_D;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto a single physical-memory port, round-robin on ties.
// Command appears one cycle after the request is sampled in IDLE; each grant is held until pmem_resp, then one RELEASE bubble.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_miss,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  contention_count
);

    arb_state_t state, next_state;
    grant_t     last_grant, next_grant;
    logic       contend;
    logic       i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or posedge reset_miss) begin
        if (reset_miss) begin
            state            <= IDLE;
            last_grant       <= GRANT_D;
            contention_count <= '0;
        end else begin
            state      <= next_state;
            last_grant <= next_grant;
            if (contend && contention_count != {CNT_W{1'b1}})
                contention_count <= contention_count + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_grant = last_grant;
        contend    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    contend    = 1'b1;
                    next_grant = rr_pick(last_grant);
                    next_state = (next_grant == GRANT_I) ? SERVE_I : SERVE_D;
                end else if (i_req) begin
                    next_grant = GRANT_I;
                    next_state = SERVE_I;
                end else if (d_req) begin
                    next_grant = GRANT_D;
                    next_state = SERVE_D;
                end
            end
            SERVE_I: if (pmem_resp) next_state = RELEASE;
            // A D-cache that withdraws its request abandons the transaction.
            SERVE_D: begin
                if (!d_req)         next_state = IDLE;
                else if (pmem_resp) next_state = RELEASE;
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_write   = d_pmem_write;
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp & d_req;
            end
            default: ;
        endcase
    end

    // Read data fans out to both caches; gated only so nothing leaks out during reset.
    assign i_pmem_rdata = reset_miss ? '0 : pmem_rdata;
    assign d_pmem_rdata = reset_miss ? '0 : pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-timeline model predicts grants and responses.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              reset_miss;
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read, d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [CNT_W-1:0]  contention_count;

    mem_arbiter dut (
        .clk(clk), .reset_miss(reset_miss),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .contention_count(contention_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wd;
    } cmd_t;

    typedef struct {
        int   cyc;
        logic side;   // 1 = D-cache
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: transaction timeline, not cycle states.
    int next_dec, resp_at, abort_at, exp_cnt;
    int serving;                       // 0 none, 1 I, 2 D
    bit last_d, i_pend, d_pend, d_rd, d_wr, i_done, d_done, gen_en, mon_en;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    // One negedge of stimulus; the edge that follows is edge 'cyc'.
    task automatic step();
        bit   d_block;
        bit   both, g_d;
        int   lat;
        cmd_t c;
        d_block = 1'b0;
        if (i_done) begin i_pend = 1'b0; i_done = 1'b0; end
        if (d_done) begin d_pend = 1'b0; d_done = 1'b0; end
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (serving == 2 && cyc == abort_at) begin
            d_pend = 1'b0; d_block = 1'b1; serving = 0; next_dec = cyc + 1;
        end
        if (serving != 0 && cyc == resp_at) begin
            pmem_resp = 1'b1;
            rsp_q.push_back('{cyc: cyc, side: (serving == 2)});
            if (serving == 1) i_done = 1'b1; else d_done = 1'b1;
            serving = 0; next_dec = cyc + 2;
        end
        if (!i_pend) begin
            i_pmem_address = 16'($urandom);
            if (gen_en && $urandom_range(0, 2) == 0) i_pend = 1'b1;
        end
        if (!d_pend && !d_block) begin
            d_pmem_address = 16'($urandom);
            d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       begin d_rd = 1'b1; d_wr = 1'b0; end
                1:       begin d_rd = 1'b0; d_wr = 1'b1; end
                default: begin d_rd = 1'b1; d_wr = 1'b1; end
            endcase
            if (gen_en && $urandom_range(0, 2) == 0) d_pend = 1'b1;
        end
        i_pmem_read  = i_pend;
        d_pmem_read  = d_pend & d_rd;
        d_pmem_write = d_pend & d_wr;
        if (serving == 0 && cyc == next_dec) begin
            if (i_pend || d_pend) begin
                both = i_pend && d_pend;
                if (both) exp_cnt++;
                g_d      = both ? !last_d : d_pend;
                last_d   = g_d;
                lat      = $urandom_range(1, 5);
                resp_at  = cyc + lat;
                abort_at = -1;
                if (g_d) begin
                    serving = 2;
                    c = '{cyc: cyc, rd: d_rd & ~d_wr, wr: d_wr, addr: d_pmem_address, wd: d_pmem_wdata};
                    if (lat >= 2 && $urandom_range(0, 5) == 0) abort_at = cyc + $urandom_range(1, lat - 1);
                end else begin
                    serving = 1;
                    c = '{cyc: cyc, rd: 1'b1, wr: 1'b0, addr: i_pmem_address, wd: '0};
                end
                cmd_q.push_back(c);
            end else begin
                next_dec = cyc + 1;
            end
        end
    endtask

    // Monitor: commands sampled after the rising edge, responses after the falling edge.
    initial begin
        cmd_t cur;
        rsp_t r;
        bit   have_cur;
        have_cur = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mon_en) begin
                check("contention_count", contention_count, exp_cnt);
                if (pmem_read || pmem_write) begin
                    if (!have_cur) begin
                        if (cmd_q.size() == 0) flag("cmd_unexpected");
                        else begin
                            cur = cmd_q.pop_front();
                            have_cur = 1'b1;
                            check("cmd_cycle", cyc, cur.cyc);
                        end
                    end
                    if (have_cur) begin
                        check("pmem_read", pmem_read, cur.rd);
                        check("pmem_write", pmem_write, cur.wr);
                        check("pmem_address", pmem_address, cur.addr);
                        check("pmem_wdata", pmem_wdata, cur.wd);
                    end
                end else begin
                    have_cur = 1'b0;
                    check("idle_address", pmem_address, '0);
                    check("idle_wdata", pmem_wdata, '0);
                end
            end
            @(negedge clk); #1;
            if (mon_en) begin
                check("i_rdata", i_pmem_rdata, pmem_rdata);
                check("d_rdata", d_pmem_rdata, pmem_rdata);
                if (i_pmem_resp || d_pmem_resp) begin
                    if (rsp_q.size() == 0) flag("resp_unexpected");
                    else begin
                        r = rsp_q.pop_front();
                        check("resp_cycle", cyc, r.cyc);
                        check("resp_side", d_pmem_resp, r.side);
                        check("resp_onehot", i_pmem_resp & d_pmem_resp, 1'b0);
                    end
                end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                    r = rsp_q.pop_front();
                    flag("resp_missing");
                end
            end
        end
    end

    initial begin
        reset_miss = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = {LINE_W{1'b1}}; pmem_resp = 1'b1;
        serving = 0; exp_cnt = 0; last_d = 1'b1; resp_at = -1; abort_at = -1; next_dec = 0;
        i_pend = 0; d_pend = 0; d_rd = 0; d_wr = 0; i_done = 0; d_done = 0;
        gen_en = 0; mon_en = 0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_i_resp", i_pmem_resp, 1'b0);
        check("rst_d_resp", d_pmem_resp, 1'b0);
        check("rst_i_rdata", i_pmem_rdata, '0);
        check("rst_count", contention_count, '0);

        // First decision after reset is a tie: I must win.
        @(negedge clk);
        cyc++;
        reset_miss = 1'b0;
        next_dec = cyc;
        gen_en = 1'b1; mon_en = 1'b1;
        i_pend = 1'b1; i_pmem_address = 16'h0100;
        d_pend = 1'b1; d_rd = 1'b1; d_wr = 1'b0; d_pmem_address = 16'h0200;
        step();

        repeat (3000) begin
            @(negedge clk); cyc++; step();
        end
        gen_en = 1'b0;
        repeat (40) begin
            @(negedge clk); cyc++; step();
        end
        @(negedge clk); #2;
        mon_en = 1'b0;
        check("drain_cmd_q", cmd_q.size(), 0);
        check("drain_rsp_q", rsp_q.size(), 0);
        check("drain_busy", {i_pend, d_pend, serving != 0}, 3'b000);

        // Directed write, then reset in the middle of a second write.
        for (int k = 0; k < 2; k++) begin
            cyc++;
            pmem_resp = 1'b0;
            d_pmem_write = 1'b1; d_pmem_read = 1'b0; d_pmem_address = 16'h1230;
            d_pmem_wdata = 128'hDEADBEEF_00000000_00000000_DEADBEEF;
            @(posedge clk); #1;
            check("dir_write", pmem_write, 1'b1);
            check("dir_read", pmem_read, 1'b0);
            check("dir_addr", pmem_address, 16'h1230);
            check("dir_wdata", pmem_wdata, 128'hDEADBEEF_00000000_00000000_DEADBEEF);
            check("dir_count", contention_count, exp_cnt);
            @(negedge clk);
            if (k == 0) begin
                pmem_resp = 1'b1; #1;
                check("dir_d_resp", d_pmem_resp, 1'b1);
                check("dir_i_resp", i_pmem_resp, 1'b0);
                @(negedge clk);
                pmem_resp = 1'b0; d_pmem_write = 1'b0; #1;
                check("dir_release", pmem_write, 1'b0);
                @(negedge clk);
            end else begin
                reset_miss = 1'b1; pmem_resp = 1'b1; #1;
                check("rst_mid_write", pmem_write, 1'b0);
                check("rst_mid_addr", pmem_address, '0);
                check("rst_mid_d_resp", d_pmem_resp, 1'b0);
                check("rst_mid_count", contention_count, '0);
                check("rst_mid_rdata", d_pmem_rdata, '0);
                @(negedge clk);
                reset_miss = 1'b0; pmem_resp = 1'b0; d_pmem_write = 1'b0;
                @(posedge clk); #1;
                check("post_rst_write", pmem_write, 1'b0);
                check("post_rst_count", contention_count, '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
